// File: rtl/load_store_buffer.sv
// rtl/load_store_buffer.sv - ROB-ordered load/store buffer with byte-serial memory port
//
// Purpose: holds one slot per ROB id (op from dispatch, address/store data
// from the reservation station). It executes a memory op only when its ROB id
// is the ROB head, moves it over the byte-serial RAM port, and broadcasts the
// result on the LS CDB.
//
// Ports:
//   clk_in, rst_in, rdy_in      clock, async active-high reset, global stall
//   _clear                      mispredict flush
//   _disp_*                     op dispatch (id, {is_store, funct3})
//   _lsb_*                      RS pop: id, store data, effective address
//   _rob_head_valid/_rob_head_id  current ROB head
//   mem_din/mem_dout/mem_a/mem_wr byte RAM port (read data one cycle after address)
//   _cdb_ls_ready/_rob_id/_value  one-cycle completion broadcast
module load_store_buffer #(
    parameter int ROB_BITS = 5
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                _clear,
    input  logic                _disp_ready,
    input  logic [ROB_BITS-1:0] _disp_rob_id,
    input  logic [3:0]          _disp_op,
    input  logic                _lsb_rs_ready,
    input  logic [ROB_BITS-1:0] _lsb_rob_id,
    input  logic [31:0]         _lsb_st_value,
    input  logic [31:0]         _lsb_ptr_value,
    input  logic                _rob_head_valid,
    input  logic [ROB_BITS-1:0] _rob_head_id,
    input  logic [7:0]          mem_din,
    output logic [7:0]          mem_dout,
    output logic [31:0]         mem_a,
    output logic                mem_wr,
    output logic                _cdb_ls_ready,
    output logic [ROB_BITS-1:0] _cdb_ls_rob_id,
    output logic [31:0]         _cdb_ls_value
);

    localparam int SLOTS = 1 << ROB_BITS;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOAD_TAIL, S_STORE, S_BCAST} state_t;

    state_t              state_q, state_d;
    logic [2:0]          k_q, k_d;
    logic [3:0]          op_q, op_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         sv_q, sv_d;
    logic [ROB_BITS-1:0] id_q, id_d;
    logic [31:0]         data_q, data_d;
    logic                st_abort_q, st_abort_d;

    logic [SLOTS-1:0]    valid_q, valid_d;
    logic [SLOTS-1:0]    ready_q, ready_d;
    logic [3:0]          sop_q   [SLOTS];
    logic [3:0]          sop_d   [SLOTS];
    logic [31:0]         saddr_q [SLOTS];
    logic [31:0]         saddr_d [SLOTS];
    logic [31:0]         ssv_q   [SLOTS];
    logic [31:0]         ssv_d   [SLOTS];

    logic [2:0]          n_bytes;
    logic                last_byte;
    logic                head_go;
    logic [1:0]          cap_sel;
    logic [31:0]         captured;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    size_of = 3'd1;
            2'd1:    size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'd0:    extend = {{24{raw[7]}}, raw[7:0]};
            3'd1:    extend = {{16{raw[15]}}, raw[15:0]};
            3'd4:    extend = {24'b0, raw[7:0]};
            3'd5:    extend = {16'b0, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        op_d       = op_q;
        addr_d     = addr_q;
        sv_d       = sv_q;
        id_d       = id_q;
        data_d     = data_q;
        st_abort_d = st_abort_q;
        valid_d    = valid_q;
        ready_d    = ready_q;
        sop_d      = sop_q;
        saddr_d    = saddr_q;
        ssv_d      = ssv_q;

        n_bytes   = size_of(op_q[2:0]);
        last_byte = (k_q == n_bytes - 3'd1);
        head_go   = _rob_head_valid && valid_q[_rob_head_id] && ready_q[_rob_head_id];
        // mem_din in this cycle belongs to the address driven last cycle (k-1).
        cap_sel   = k_q[1:0] - 2'd1;
        captured  = data_q;
        captured[{cap_sel, 3'b000} +: 8] = mem_din;

        if (rdy_in) begin
            if (_clear) begin
                valid_d = '0;
            end else begin
                if (state_q == S_BCAST) valid_d[id_q] = 1'b0;
                if (_lsb_rs_ready) begin
                    ready_d[_lsb_rob_id] = 1'b1;
                    saddr_d[_lsb_rob_id] = _lsb_ptr_value;
                    ssv_d[_lsb_rob_id]   = _lsb_st_value;
                end
                // Applied last so a dispatch to the same slot wins.
                if (_disp_ready) begin
                    valid_d[_disp_rob_id] = 1'b1;
                    ready_d[_disp_rob_id] = 1'b0;
                    sop_d[_disp_rob_id]   = _disp_op;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (!_clear && head_go) begin
                        op_d       = sop_q[_rob_head_id];
                        addr_d     = saddr_q[_rob_head_id];
                        sv_d       = ssv_q[_rob_head_id];
                        id_d       = _rob_head_id;
                        k_d        = 3'd0;
                        data_d     = '0;
                        st_abort_d = 1'b0;
                        state_d    = sop_q[_rob_head_id][3] ? S_STORE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (_clear) begin
                        state_d = S_IDLE;
                        k_d     = 3'd0;
                    end else begin
                        if (k_q != 3'd0) data_d = captured;
                        k_d = k_q + 3'd1;
                        if (last_byte) state_d = S_LOAD_TAIL;
                    end
                end
                S_LOAD_TAIL: begin
                    k_d = 3'd0;
                    if (_clear) begin
                        state_d = S_IDLE;
                    end else begin
                        data_d  = extend(op_q[2:0], captured);
                        state_d = S_BCAST;
                    end
                end
                S_STORE: begin
                    // A flush never truncates a store; it only suppresses the broadcast.
                    if (_clear) st_abort_d = 1'b1;
                    k_d = k_q + 3'd1;
                    if (last_byte) begin
                        k_d     = 3'd0;
                        state_d = (st_abort_q || _clear) ? S_IDLE : S_BCAST;
                    end
                end
                S_BCAST: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    k_d     = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            k_q        <= 3'd0;
            op_q       <= '0;
            addr_q     <= '0;
            sv_q       <= '0;
            id_q       <= '0;
            data_q     <= '0;
            st_abort_q <= 1'b0;
            valid_q    <= '0;
            ready_q    <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            sv_q       <= sv_d;
            id_q       <= id_d;
            data_q     <= data_d;
            st_abort_q <= st_abort_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
        end
    end

    // Slot payload is only meaningful while the slot is valid, so it needs no reset.
    always_ff @(posedge clk_in) begin
        sop_q   <= sop_d;
        saddr_q <= saddr_d;
        ssv_q   <= ssv_d;
    end

    always_comb begin
        mem_a          = '0;
        mem_dout       = '0;
        mem_wr         = 1'b0;
        _cdb_ls_ready  = 1'b0;
        _cdb_ls_rob_id = '0;
        _cdb_ls_value  = '0;
        case (state_q)
            // While stalled, keep re-reading the byte not yet captured so the
            // resume cycle sees its data on mem_din.
            S_LOAD:      mem_a = addr_q + 32'((rdy_in || k_q == 3'd0) ? k_q : k_q - 3'd1);
            S_LOAD_TAIL: mem_a = addr_q + 32'(k_q - 3'd1);
            S_STORE: begin
                mem_a    = addr_q + 32'(k_q);
                mem_dout = sv_q[{k_q[1:0], 3'b000} +: 8];
                mem_wr   = rdy_in;
            end
            S_BCAST: begin
                _cdb_ls_ready  = rdy_in && !_clear;
                _cdb_ls_rob_id = id_q;
                _cdb_ls_value  = data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_buffer.sv
// tb/tb_load_store_buffer.sv - directed table-driven bench for load_store_buffer
module tb_load_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        disp_ready = 1'b0;
    logic [4:0]  disp_id = '0;
    logic [3:0]  disp_op = '0;
    logic        rs_ready = 1'b0;
    logic [4:0]  rs_id = '0;
    logic [31:0] st_value = '0;
    logic [31:0] ptr_value = '0;
    logic        head_valid = 1'b0;
    logic [4:0]  head_id = '0;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        cdb_ready;
    logic [4:0]  cdb_id;
    logic [31:0] cdb_value;

    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    logic [7:0]  ram [4096];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    load_store_buffer #(.ROB_BITS(5)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), ._clear(clear),
        ._disp_ready(disp_ready), ._disp_rob_id(disp_id), ._disp_op(disp_op),
        ._lsb_rs_ready(rs_ready), ._lsb_rob_id(rs_id),
        ._lsb_st_value(st_value), ._lsb_ptr_value(ptr_value),
        ._rob_head_valid(head_valid), ._rob_head_id(head_id),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        ._cdb_ls_ready(cdb_ready), ._cdb_ls_rob_id(cdb_id), ._cdb_ls_value(cdb_value)
    );

    // Byte RAM: read data for an address appears one cycle after it is driven.
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    typedef struct {
        string       name;
        logic [4:0]  id;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sv;
        logic [31:0] bytes;
        logic        preload;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [3:0] op);
        case (op[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    task automatic drive_defaults();
        disp_ready = 1'b0;
        rs_ready   = 1'b0;
        clear      = 1'b0;
        rdy        = 1'b1;
        pl_en      = 1'b0;
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk); drive_defaults();
        pl_en = 1'b1; pl_addr = a[11:0]; pl_data = d;
    endtask

    task automatic dispatch(input logic [4:0] id, input logic [3:0] op);
        @(negedge clk); drive_defaults();
        disp_ready = 1'b1; disp_id = id; disp_op = op;
    endtask

    task automatic rs(input logic [4:0] id, input logic [31:0] a, input logic [31:0] sv);
        @(negedge clk); drive_defaults();
        rs_ready = 1'b1; rs_id = id; ptr_value = a; st_value = sv;
    endtask

    task automatic start_head(input logic [4:0] id);
        @(negedge clk); drive_defaults();
        head_valid = 1'b1; head_id = id;
    endtask

    task automatic step();
        @(negedge clk); drive_defaults(); #1;
    endtask

    task automatic wait_bcast(input string name, input logic [4:0] id, input logic [31:0] val);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (cdb_ready) begin
                seen = 1'b1;
                chk({name, " id"}, 32'(cdb_id), 32'(id));
                chk({name, " value"}, cdb_value, val);
            end
        end
        chk({name, " seen"}, 32'(seen), 32'd1);
    endtask

    task automatic quiet(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            step();
            chk({name, " ready"}, 32'(cdb_ready), 32'd0);
            chk({name, " mem_a"}, mem_a, 32'd0);
        end
    endtask

    function automatic logic [31:0] ram_word(input int a);
        return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"LW",   5'd3,  4'b0010, 32'h100, 32'h0,        32'h80332211, 1'b1, 32'h80332211};
        tbl[1] = '{"LB",   5'd4,  4'b0000, 32'h200, 32'h0,        32'h000000F0, 1'b1, 32'hFFFFFFF0};
        tbl[2] = '{"LBU",  5'd5,  4'b0100, 32'h200, 32'h0,        32'h0,        1'b0, 32'h000000F0};
        tbl[3] = '{"LH",   5'd6,  4'b0001, 32'h201, 32'h0,        32'h00000080, 1'b1, 32'h00000080};
        tbl[4] = '{"LHU",  5'd8,  4'b0101, 32'h204, 32'h0,        32'h0000FFFE, 1'b1, 32'h0000FFFE};
        tbl[5] = '{"LHs",  5'd12, 4'b0001, 32'h204, 32'h0,        32'h0,        1'b0, 32'hFFFFFFFE};
        tbl[6] = '{"SH",   5'd7,  4'b1001, 32'h300, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0};
        tbl[7] = '{"SW",   5'd9,  4'b1010, 32'h310, 32'h12345678, 32'h0,        1'b0, 32'h0};
        tbl[8] = '{"LWrb", 5'd10, 4'b0010, 32'h310, 32'h0,        32'h0,        1'b0, 32'h12345678};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst mem_a", mem_a, 32'd0);
        chk("rst mem_dout", 32'(mem_dout), 32'd0);
        chk("rst mem_wr", 32'(mem_wr), 32'd0);
        chk("rst cdb_ready", 32'(cdb_ready), 32'd0);
        chk("rst cdb_id", 32'(cdb_id), 32'd0);
        chk("rst cdb_value", cdb_value, 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            int n, lat;
            bit st;
            n   = nbytes(tbl[v].op);
            st  = tbl[v].op[3];
            lat = st ? n + 1 : n + 2;
            if (tbl[v].preload)
                for (int b = 0; b < n; b++) poke(tbl[v].addr + 32'(b), tbl[v].bytes[8*b +: 8]);
            dispatch(tbl[v].id, tbl[v].op);
            rs(tbl[v].id, tbl[v].addr, tbl[v].sv);
            start_head(tbl[v].id);
            for (int c = 1; c <= lat + 1; c++) begin
                step();
                if (c <= n) begin
                    chk({tbl[v].name, " mem_a"}, mem_a, tbl[v].addr + 32'(c - 1));
                    chk({tbl[v].name, " mem_wr"}, 32'(mem_wr), 32'(st));
                    if (st) chk({tbl[v].name, " mem_dout"}, 32'(mem_dout), 32'(tbl[v].sv[8*(c-1) +: 8]));
                end
                if (c == lat) begin
                    chk({tbl[v].name, " cdb_ready"}, 32'(cdb_ready), 32'd1);
                    chk({tbl[v].name, " cdb_id"}, 32'(cdb_id), 32'(tbl[v].id));
                    chk({tbl[v].name, " cdb_value"}, cdb_value, tbl[v].exp);
                end else begin
                    chk({tbl[v].name, " no pulse"}, 32'(cdb_ready), 32'd0);
                end
            end
            head_valid = 1'b0;
        end

        // Head ordering: id 5 ready first but waits for head 4
        start_head(5'd4);
        dispatch(5'd4, 4'b0010);
        dispatch(5'd5, 4'b0000);
        rs(5'd5, 32'h200, 32'h0);
        quiet("order wait", 5);
        rs(5'd4, 32'h100, 32'h0);
        wait_bcast("order head4", 5'd4, 32'h80332211);
        quiet("order idle", 3);
        head_id = 5'd5;
        wait_bcast("order head5", 5'd5, 32'hFFFFFFF0);
        head_valid = 1'b0;

        // Flush mid-LW after two bytes
        dispatch(5'd3, 4'b0010);
        rs(5'd3, 32'h100, 32'h0);
        start_head(5'd3);
        step(); step();
        chk("clr lw mem_a", mem_a, 32'h101);
        @(negedge clk); drive_defaults(); clear = 1'b1; #1;
        chk("clr lw ready", 32'(cdb_ready), 32'd0);
        quiet("clr lw after", 4);
        rs(5'd3, 32'h100, 32'h0);
        quiet("clr lw slot", 6);
        head_valid = 1'b0;

        // Flush mid-SW after byte 1: remaining bytes still written
        dispatch(5'd9, 4'b1010);
        rs(5'd9, 32'h340, 32'hCAFEBABE);
        start_head(5'd9);
        step();
        chk("clr sw b0 wr", 32'(mem_wr), 32'd1);
        @(negedge clk); drive_defaults(); clear = 1'b1; #1;
        chk("clr sw b1 a", mem_a, 32'h341);
        step();
        chk("clr sw b2 a", mem_a, 32'h342);
        chk("clr sw b2 wr", 32'(mem_wr), 32'd1);
        chk("clr sw b2 dout", 32'(mem_dout), 32'hFE);
        step();
        chk("clr sw b3 a", mem_a, 32'h343);
        chk("clr sw b3 dout", 32'(mem_dout), 32'hCA);
        quiet("clr sw after", 5);
        chk("clr sw ram", ram_word(32'h340), 32'hCAFEBABE);
        head_valid = 1'b0;

        // rdy_in low for 3 cycles mid-LW: broadcast at T+9
        dispatch(5'd3, 4'b0010);
        rs(5'd3, 32'h100, 32'h0);
        start_head(5'd3);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk); drive_defaults();
            rdy = !(c >= 3 && c <= 5);
            #1;
            if (c < 9) chk("stall lw early", 32'(cdb_ready), 32'd0);
            else begin
                chk("stall lw ready", 32'(cdb_ready), 32'd1);
                chk("stall lw value", cdb_value, 32'h80332211);
            end
        end
        head_valid = 1'b0;

        // rdy_in low mid-SW: writes suppressed, then resumed
        dispatch(5'd10, 4'b1010);
        rs(5'd10, 32'h350, 32'h01020304);
        start_head(5'd10);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk); drive_defaults();
            rdy = !(c == 2 || c == 3);
            #1;
            if (c == 2 || c == 3) chk("stall sw wr", 32'(mem_wr), 32'd0);
            if (c == 4) chk("stall sw resume a", mem_a, 32'h351);
            chk("stall sw ready", 32'(cdb_ready), 32'(c == 7));
        end
        step();
        chk("stall sw ram", ram_word(32'h350), 32'h01020304);
        head_valid = 1'b0;

        // Asynchronous reset mid-store
        dispatch(5'd11, 4'b1010);
        rs(5'd11, 32'h360, 32'hA5A5A5A5);
        start_head(5'd11);
        step();
        chk("arst pre wr", 32'(mem_wr), 32'd1);
        step();
        rst = 1'b1;
        #1;
        chk("arst mem_wr", 32'(mem_wr), 32'd0);
        chk("arst mem_a", mem_a, 32'd0);
        chk("arst mem_dout", 32'(mem_dout), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rs(5'd11, 32'h360, 32'hA5A5A5A5);
        quiet("arst slot", 5);
        head_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
